// File: rtl/crc_stream.sv
// rtl/crc_stream.sv - streaming parametrised CRC engine with registered result handshake
//
// Purpose: folds a packet of DATA_W-bit beats into a running CRC. The last beat carries
// a contiguous byte-enable. It emits the finalised CRC plus the byte count through a
// one-entry output register.
//
// Optional feature macro: CRC_CHECK_EN. When it is defined, m_match is registered as
// (final CRC == RESIDUE) and the RESIDUE parameter exists. When it is undefined,
// m_match is tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_valid/s_ready           input beat handshake
//   s_data [DATA_W]           beat data, byte k = s_data[8k+7:8k], byte 0 first on the wire
//   s_keep [DATA_W/8]         byte enables, honoured on the last beat only
//   s_last                    final beat of the frame
//   m_valid/m_ready           result handshake
//   m_crc [CRC_W]             finalised CRC
//   m_len [LEN_W]             frame length in bytes (saturating)
//   m_match                   m_crc == RESIDUE (CRC_CHECK_EN only)
module crc_stream #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter int unsigned LEN_W       = 16
`ifdef CRC_CHECK_EN
  ,
  parameter logic [31:0] RESIDUE     = 32'h2144DF1C
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CRC_W-1:0]    m_crc,
  output logic [LEN_W-1:0]    m_len,
  output logic                m_match
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned CW = $clog2(NB + 1);

  // Constants zero-extended or truncated to the CRC width.
  localparam logic [CRC_W-1:0] POLY_C = CRC_W'(POLY);
  localparam logic [CRC_W-1:0] INIT_C = CRC_W'(INIT);
  localparam logic [CRC_W-1:0] XOR_C  = CRC_W'(XOR_OUT);

  logic [CRC_W-1:0] crc_q;
  logic [LEN_W-1:0] len_q;

  logic             beat_acc;
  logic [CW-1:0]    n_keep;
  logic [CW-1:0]    n_bytes;
  logic [CRC_W-1:0] chain [0:NB];
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_fin;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_next;
  logic [NB-1:0]    keep_inc;
  logic             keep_legal;

  // Bit-serial update of one byte, MSB-first register. With reflected input, bit 0
  // enters first; the output reflection is applied only at finalisation.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] b);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[CRC_W-1] ^ (REFLECT_IN ? b[i] : b[7-i]);
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  assign s_ready  = !m_valid || m_ready;
  assign beat_acc = s_valid && s_ready;

  // A legal keep has the form 2^n-1: adding one clears every set bit.
  assign keep_inc   = s_keep + NB'(1);
  assign keep_legal = ((keep_inc & s_keep) == '0);

  always_comb begin
    n_keep = '0;
    for (int i = 0; i < NB; i++) n_keep = n_keep + CW'(s_keep[i]);
    n_bytes = s_last ? n_keep : CW'(NB);
  end

  // CRC after each prefix length of the beat; the byte count selects the tap.
  always_comb begin
    chain[0] = crc_q;
    for (int k = 0; k < NB; k++) chain[k+1] = crc_byte(chain[k], s_data[8*k +: 8]);
    crc_next = chain[n_bytes];
    crc_fin  = (REFLECT_OUT ? rev(crc_next) : crc_next) ^ XOR_C;
  end

  always_comb begin
    len_sum  = {1'b0, len_q} + (LEN_W+1)'(n_bytes);
    len_next = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q   <= INIT_C;
      len_q   <= '0;
      m_valid <= 1'b0;
      m_crc   <= '0;
      m_len   <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (beat_acc) begin
        if (s_last) begin
          m_valid <= 1'b1;
          m_crc   <= crc_fin;
          m_len   <= len_next;
          crc_q   <= INIT_C;
          len_q   <= '0;
        end else begin
          crc_q <= crc_next;
          len_q <= len_next;
        end
      end
    end
  end

`ifdef CRC_CHECK_EN
  localparam logic [CRC_W-1:0] RES_C = CRC_W'(RESIDUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_match <= 1'b0;
    end else if (beat_acc && s_last) begin
      m_match <= (crc_fin == RES_C);
    end
  end
`else
  assign m_match = 1'b0;
`endif

  // Non-contiguous byte enables on a last beat give an undefined result.
  always_ff @(posedge clk) begin
    if (!rst && beat_acc && s_last) assert (keep_legal);
  end

endmodule
